// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: writes a pattern to every RAM word, then reads each word back
// and counts mismatches.
module mem_test_sequencer #(
  parameter int unsigned DEPTH  = 32000,
  parameter int unsigned ADDR_W = 15,
  parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern_sel,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;
  logic              in_pass;
  logic              kill;

  function automatic logic [31:0] pattern_of(input logic [1:0] sel, input logic [ADDR_W-1:0] addr);
    logic [31:0] a;
    a = 32'(addr);
    case (sel)
      2'd0:    pattern_of = a;
      2'd1:    pattern_of = ~a;
      2'd2:    pattern_of = SEED;
      default: pattern_of = a[0] ? 32'h5555_AAAA : 32'hAAAA_5555;
    endcase
  endfunction

  assign in_pass = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
  // An abort discards whatever compare is pending in the same cycle.
  assign kill    = abort && in_pass;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    err_d       = err_q;
    first_d     = first_q;
    pass_d      = pass_q;

    if (cmp_valid_q && !kill && (mem_readdata != pattern_of(sel_q, cmp_addr_q))) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    first_d = cmp_addr_q;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = pattern_sel;
          err_d   = 16'd0;
          first_d = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StRead: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cmp_valid_d = 1'b1;
          cmp_addr_d  = cnt_q;
          if (cnt_q == LastAddr) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          // Includes the final compare that lands in this cycle.
          pass_d  = (err_d == 16'd0);
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      err_q       <= 16'd0;
      first_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      err_q       <= err_d;
      first_q     <= first_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = 32'd0;
    unique case (state_q)
      StWrite: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = cnt_q;
        mem_writedata  = pattern_of(sel_q, cnt_q);
      end
      StRead: begin
        mem_chipselect = 1'b1;
        mem_address    = cnt_q;
      end
      default: ;
    endcase
  end

  assign mem_byteenable = in_pass ? 4'hF : 4'h0;
  assign mem_clken      = 1'b1;
  assign busy           = in_pass;
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Bench for mem_test_sequencer: 16-word behavioural RAM with fault injection, directed
// scenarios plus randomized passes checked against an address-by-address error model.
module tb_mem_test_sequencer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] SEED   = 32'hA5A5_5A5A;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [1:0]        pattern_sel;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata, mem_readdata;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  int total = 0;
  int bad   = 0;

  // RAM model state and fault controls
  logic [31:0] ram   [DEPTH];
  logic [31:0] flip  [DEPTH];
  logic [31:0] stuck [DEPTH];
  logic        zero_mode;

  mem_test_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEED(SEED)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .pattern_sel    (pattern_sel),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
    if (mem_chipselect && !mem_write)
      mem_readdata <= zero_mode ? 32'd0
                    : ((ram[mem_address] ^ flip[mem_address]) | stuck[mem_address]);
  end

  function automatic logic [31:0] pat(input logic [1:0] s, input int a);
    case (s)
      2'd0:    return 32'(a);
      2'd1:    return ~32'(a);
      2'd2:    return SEED;
      default: return (a % 2 == 1) ? 32'h5555_AAAA : 32'hAAAA_5555;
    endcase
  endfunction

  // Expected outcome if the RAM holds exactly the written pattern, seen through the faults.
  task automatic model(input logic [1:0] s, output int e, output int f);
    logic [31:0] v;
    e = 0;
    f = 0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      v = zero_mode ? 32'd0 : ((pat(s, a) ^ flip[a]) | stuck[a]);
      if (v != pat(s, a)) begin
        if (e == 0) f = a;
        e++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    zero_mode = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      flip[a]  = 32'd0;
      stuck[a] = 32'd0;
    end
  endtask

  // One full pass, cycle n = n-th cycle after the start cycle; extra_start pulses start mid-pass.
  task automatic run_pass(input string tag, input logic [1:0] sel, input int extra_start);
    int done_at, done_cnt, proto_bad, exp_e, exp_f;
    logic        pass_at;
    logic [15:0] err_at;
    logic [31:0] first_at;
    logic        e_cs, e_wr, e_busy;
    logic [31:0] e_addr, e_wd;
    model(sel, exp_e, exp_f);
    pattern_sel = sel;
    start = 1'b1;
    cyc();
    start = 1'b0;
    pattern_sel = 2'($urandom);
    done_at = -1; done_cnt = 0; proto_bad = 0;
    pass_at = 1'b0; err_at = 16'd0; first_at = 32'd0;
    for (int n = 1; n <= 40; n++) begin
      e_cs   = (n <= 32);
      e_wr   = (n <= 16);
      e_busy = (n <= 33);
      e_addr = (n <= 16) ? 32'(n - 1) : (n <= 32) ? 32'(n - 17) : 32'd0;
      e_wd   = (n <= 16) ? pat(sel, n - 1) : 32'd0;
      if (mem_chipselect !== e_cs || mem_write !== e_wr || busy !== e_busy
          || 32'(mem_address) !== e_addr || mem_writedata !== e_wd
          || mem_byteenable !== (e_busy ? 4'hF : 4'h0) || mem_clken !== 1'b1)
        proto_bad++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n; pass_at = pass; err_at = err_count; first_at = 32'(first_err_addr);
        end
      end
      if (n == extra_start) start = 1'b1;
      cyc();
      start = 1'b0;
    end
    check({tag, ".done_at"}, 32'(done_at), 32'd34);
    check({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, ".proto"}, 32'(proto_bad), 32'd0);
    check({tag, ".pass"}, 32'(pass_at), 32'(exp_e == 0));
    check({tag, ".err"}, 32'(err_at), 32'(exp_e));
    check({tag, ".first"}, first_at, 32'(exp_f));
    check({tag, ".hold_pass"}, 32'(pass), 32'(exp_e == 0));
    check({tag, ".hold_err"}, 32'(err_count), 32'(exp_e));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".pass"}, 32'(pass), 32'd0);
    check({tag, ".err"}, 32'(err_count), 32'd0);
    check({tag, ".first"}, 32'(first_err_addr), 32'd0);
    check({tag, ".cs"}, 32'(mem_chipselect), 32'd0);
    check({tag, ".wr"}, 32'(mem_write), 32'd0);
    check({tag, ".addr"}, 32'(mem_address), 32'd0);
    check({tag, ".wdata"}, mem_writedata, 32'd0);
    check({tag, ".be"}, 32'(mem_byteenable), 32'd0);
    check({tag, ".clken"}, 32'(mem_clken), 32'd1);
  endtask

  initial begin
    int done_cnt;
    logic [1:0] s;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pattern_sel = 2'd0;
    clear_faults();
    cyc();
    cyc();
    check_reset_vals("por");
    reset = 1'b0;
    cyc();

    // Clean RAM, address pattern
    run_pass("clean_addr", 2'd0, 0);

    // Bit 0 stuck high at address 5 with an even SEED
    stuck[5] = 32'd1;
    run_pass("stuck5", 2'd2, 0);
    check("stuck5.first_is5", 32'(first_err_addr), 32'd5);
    clear_faults();

    // Alternating pattern: spot-check written words
    run_pass("alt", 2'd3, 0);
    check("alt.ram6", ram[6], 32'hAAAA_5555);
    check("alt.ram7", ram[7], 32'h5555_AAAA);

    // All reads zero, inverted address
    zero_mode = 1'b1;
    run_pass("zero_inv", 2'd1, 0);
    check("zero_inv.err16", 32'(err_count), 32'd16);

    // Reset in the middle of READ, errors already accumulating
    pattern_sel = 2'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 1; n < 20; n++) cyc();
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    cyc();
    reset = 1'b0;
    clear_faults();
    cyc();
    // A start pulse during cycle 3 must not restart the pass
    run_pass("after_reset", 2'd0, 3);

    // start and abort together in IDLE: start wins; abort at cycle 20
    pattern_sel = 2'd0;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort.start_wins", 32'(busy), 32'd1);
    for (int n = 1; n < 20; n++) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.cs", 32'(mem_chipselect), 32'd0);
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) done_cnt++;
      cyc();
    end
    check("abort.no_done", 32'(done_cnt), 32'd0);
    check("abort.pass", 32'(pass), 32'd0);
    run_pass("post_abort", 2'd0, 0);

    // Randomized passes with random single-bit corruptions
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      for (int a = 0; a < int'(DEPTH); a++)
        if ($urandom_range(3, 0) == 0) flip[a] = 32'd1 << $urandom_range(31, 0);
      s = 2'($urandom);
      run_pass($sformatf("rand%0d", r), s, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_test_sequencer.md
MEM_TEST_SEQUENCER -- requirements
Module: mem_test_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32000, number of 32-bit words tested (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, default 15, memory address width.
REQ-003 SHALL have parameter SEED, default 32'hA5A5_5A5A, constant pattern value.
REQ-004 Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a test pass.
- abort  in  1  one-cycle pulse; terminates a running pass.
- pattern_sel  in  2  0 = address, 1 = ~address, 2 = SEED, 3 = alternating 32'hAAAA_5555 (even) / 32'h5555_AAAA (odd).
- mem_address  out  ADDR_W  word address to the single-port RAM.
- mem_byteenable  out  4  byte enables; 4'hF while busy, 4'h0 otherwise.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  32  RAM read data, valid one cycle after address is presented with chipselect=1, write=0.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at completion of an unaborted pass.
- pass  out  1  result of last completed pass; 1 = zero mismatches.
- err_count  out  16  mismatch count of current/last pass, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch in current/last pass.

Function
REQ-005 FSM states SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-006 IDLE: start=1 SHALL latch pattern_sel, clear err_count to 0, first_err_addr to 0, pass to 0, set address counter to 0, go to WRITE next cycle.
REQ-007 start while not IDLE SHALL be ignored.
REQ-008 WRITE: each cycle SHALL drive mem_chipselect=1, mem_write=1, mem_address=counter, mem_writedata=pattern(counter); counter increments; after address DEPTH-1 counter resets to 0 and FSM goes to READ.
REQ-009 WRITE SHALL take exactly DEPTH cycles; no idle cycles between words.
REQ-010 READ: each cycle SHALL drive mem_chipselect=1, mem_write=0, mem_address=counter; after issuing DEPTH-1 go to DRAIN.
REQ-011 Compare stage: one cycle after each read address is issued, mem_readdata SHALL be compared to pattern(that address), using a one-cycle delayed address/valid register.
REQ-012 On mismatch: err_count increments (saturates at 16'hFFFF); if err_count was 0, first_err_addr captures the compared address.
REQ-013 DRAIN: one cycle, chipselect=0, completes compare of address DEPTH-1, then DONE.
REQ-014 DONE: one cycle; done=1, pass=(err_count==0) using the final count including DRAIN compare; next state IDLE.
REQ-015 Total pass latency from start cycle to done pulse SHALL be 2*DEPTH+2 cycles.
REQ-016 busy SHALL be 1 in WRITE, READ, DRAIN; 0 in IDLE and DONE.
REQ-017 abort in WRITE/READ/DRAIN SHALL return to IDLE next cycle, deassert chipselect/write, suppress done, leave pass=0; err_count/first_err_addr hold; pending compare discarded.
REQ-018 abort and start in the same cycle in IDLE: start SHALL win; abort in IDLE/DONE ignored.
REQ-019 Outside WRITE/READ, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0.
REQ-020 pass, err_count, first_err_addr SHALL hold after DONE until next accepted start.

Reset
REQ-021 reset SHALL asynchronously force state IDLE, counter 0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, all mem_* outputs 0 except mem_clken=1.
REQ-022 reset asserted mid-pass SHALL abandon the pass with no done pulse; first start after deassertion SHALL run a full pass.

Verification
REQ-023 Bench SHALL cover, with a behavioural 1-cycle-latency RAM model and DEPTH=16:
- Clean RAM, pattern_sel=0, start -> writes 0..15 with data=address, done at cycle 34 after start, pass=1, err_count=0.
- Model forces bit 0 stuck at 1 at address 5, pattern_sel=2 (SEED even LSB=0) -> err_count=1, first_err_addr=5, pass=0.
- All reads return 0, pattern_sel=1 -> err_count=16, first_err_addr=0, pass=0.
- abort at cycle 20 after start -> busy=0 next cycle, no done pulse, chipselect=0; subsequent start gives done and pass=1.
- reset asserted during READ -> all outputs at reset values immediately; start pulse while busy at cycle 3 -> no restart, done still at cycle 34.
- pattern_sel=3 -> address 6 written 32'hAAAA_5555, address 7 written 32'h5555_AAAA.
